// File: rtl/vga_sync_decoder_pkg.sv
// Shared timing defaults, FSM encoding and counter helpers for the VGA sync decoder.
package vga_sync_decoder_pkg;

    localparam int H_ACTIVE_DEF    = 640;
    localparam int H_FRONT_DEF     = 16;
    localparam int H_SYNC_DEF      = 96;
    localparam int H_TOTAL_DEF     = 800;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int V_FRONT_DEF     = 10;
    localparam int V_SYNC_DEF      = 2;
    localparam int V_TOTAL_DEF     = 525;
    localparam int LOCK_FRAMES_DEF = 2;

    localparam int CNT_W  = 10;
    localparam int GOOD_W = 4;

    typedef enum logic [1:0] {
        ACQ_H  = 2'b00,
        ACQ_V  = 2'b01,
        VERIFY = 2'b10,
        LOCKED = 2'b11
    } state_e;

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v, input int total);
        return (v == CNT_W'(total - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_detector.sv
// Two-flop synchronizer for one sync line, polarity-normalized, with assert/deassert pulses.
// Pulses are valid 2 cycles after the pin changes; no backpressure, free-running.
module sync_edge_detector #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic asrt_o,
    output logic deasrt_o
);
    logic meta_q;
    logic sync_q;
    logic level_q;
    logic norm;

    assign norm = sync_q ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= ACTIVE_LOW;
            sync_q  <= ACTIVE_LOW;
            level_q <= 1'b0;
        end else begin
            meta_q  <= sync_i;
            sync_q  <= meta_q;
            level_q <= norm;
        end
    end

    assign asrt_o   = norm & ~level_q;
    assign deasrt_o = ~norm & level_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel X/Y and display enable from sampled VGA sync lines; locks after consistent frames.
// rx_x/rx_y trail the transmitter counters by 3 cycles; all outputs registered, no backpressure.
module vga_sync_decoder
    import vga_sync_decoder_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_TOTAL         = H_TOTAL_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_TOTAL         = V_TOTAL_DEF,
    parameter int LOCK_FRAMES     = LOCK_FRAMES_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vga_h_sync,
    input  logic             vga_v_sync,
    output logic [CNT_W-1:0] rx_x,
    output logic [CNT_W-1:0] rx_y,
    output logic             rx_de,
    output logic             frame_start,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       err_count
);
    localparam logic [CNT_W-1:0]  H_LOAD      = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0]  H_SYNC_END  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0]  H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  H_VIS       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_LOAD      = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0]  V_SYNC_END  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0]  V_VIS       = CNT_W'(V_ACTIVE);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_FRAMES);

    logic h_asrt, h_deasrt, v_asrt, v_deasrt;

    sync_edge_detector #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync (
        .clk      (clk),
        .rst_n    (reset_n),
        .sync_i   (vga_h_sync),
        .asrt_o   (h_asrt),
        .deasrt_o (h_deasrt)
    );

    sync_edge_detector #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync (
        .clk      (clk),
        .rst_n    (reset_n),
        .sync_i   (vga_v_sync),
        .asrt_o   (v_asrt),
        .deasrt_o (v_deasrt)
    );

    logic [CNT_W-1:0]  h_q, h_d, h_inc, v_q, v_d, v_nat;
    logic              h_wrap, v_load, v_pend_q, v_pend_d;
    state_e            state_q;
    logic [GOOD_W-1:0] good_q, good_inc;
    logic              h_bad, v_bad, err, lock_done, locked_d;
    logic              locked_q, rx_de_q, frame_start_q, sync_err_q;
    logic [7:0]        err_count_q;

    // A vsync edge seen mid-line is held until the line wraps, then V snaps to the sync line.
    always_comb begin
        h_inc    = wrap_inc(h_q, H_TOTAL);
        h_wrap   = !h_asrt && (h_q == H_LAST);
        h_d      = h_asrt ? H_LOAD : h_inc;
        v_nat    = h_wrap ? wrap_inc(v_q, V_TOTAL) : v_q;
        v_load   = h_wrap && (v_pend_q || v_asrt);
        v_d      = v_load ? V_LOAD : v_nat;
        v_pend_d = h_wrap ? 1'b0 : (v_pend_q || v_asrt);
    end

    // Checks compare the value the counter is about to take, not its current value.
    always_comb begin
        h_bad     = (state_q != ACQ_H) &&
                    ((h_asrt && (h_inc != H_LOAD)) || (h_deasrt && (h_inc != H_SYNC_END)));
        v_bad     = (state_q inside {VERIFY, LOCKED}) &&
                    ((v_asrt && (v_nat != V_LOAD)) || (v_deasrt && (v_nat != V_SYNC_END)));
        err       = h_bad || v_bad;
        good_inc  = good_q + 1'b1;
        lock_done = (state_q == VERIFY) && v_asrt && (good_inc == GOOD_TARGET);
        locked_d  = !err && (lock_done || (state_q == LOCKED));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ACQ_H;
            good_q        <= '0;
            h_q           <= '0;
            v_q           <= '0;
            v_pend_q      <= 1'b0;
            locked_q      <= 1'b0;
            rx_de_q       <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_count_q   <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            v_pend_q      <= v_pend_d;
            sync_err_q    <= err;
            locked_q      <= locked_d;
            rx_de_q       <= locked_d && (h_d < H_VIS) && (v_d < V_VIS);
            frame_start_q <= locked_d && (h_d == '0) && (v_d == '0);
            if (err && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (err) begin
                state_q <= ACQ_H;
            end else begin
                case (state_q)
                    ACQ_H:  if (h_asrt) state_q <= ACQ_V;
                    ACQ_V:  if (v_asrt) begin
                                state_q <= VERIFY;
                                good_q  <= '0;
                            end
                    VERIFY: if (v_asrt) begin
                                good_q <= good_inc;
                                if (lock_done) state_q <= LOCKED;
                            end
                    default: ;
                endcase
            end
        end
    end

    assign rx_x        = h_q;
    assign rx_y        = v_q;
    assign rx_de       = rx_de_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: small-format sync generator, coordinate scoreboard, fault table.
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    localparam int HA = 16, HF = 4, HS = 6, HT = 32;
    localparam int VA = 10, VF = 2, VS = 2, VT = 16;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vga_h_sync = 1'b1;
    logic       vga_v_sync = 1'b1;
    logic [9:0] rx_x, rx_y;
    logic       rx_de, frame_start, locked, sync_err;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err), .err_count(err_count)
    );

    typedef struct packed { logic [9:0] x; logic [9:0] y; logic de; logic fs; } pix_t;
    typedef struct {
        string name; int sa; int ea; bit skip; int vsa;
        int exp_errs; bit exp_locked; int relock_lo; int relock_hi;
    } vec_t;

    int   n_vec = 0, n_bad = 0;
    int   tx_h = 0, tx_v = 0;
    bit   gen_run = 0, vs_en = 1, all_lines_fault = 0, chk_en = 0, f_skip = 0;
    int   fault_line = -1, f_sa = 0, f_ea = 0, f_vsa = 0;
    int   err_pulses = 0, exp_err = 0;
    pix_t sb_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_pins();
        bit hs, vs, faulty;
        faulty = all_lines_fault || (tx_v == fault_line);
        if (faulty && f_skip) hs = 1'b0;
        else if (faulty)      hs = (tx_h >= HA + HF + f_sa) && (tx_h < HA + HF + HS + f_ea);
        else                  hs = (tx_h >= HA + HF) && (tx_h < HA + HF + HS);
        vs = vs_en && (tx_v >= VA + VF + f_vsa) && (tx_v < VA + VF + VS);
        vga_h_sync = ~hs;
        vga_v_sync = ~vs;
    endtask

    task automatic push_cur();
        pix_t p;
        p.x  = 10'(tx_h);
        p.y  = 10'(tx_v);
        p.de = (tx_h < HA) && (tx_v < VA);
        p.fs = (tx_h == 0) && (tx_v == 0);
        sb_q.push_back(p);
    endtask

    // The DUT sees pins 3 cycles late, so the entry pushed 3 ticks ago is due now.
    task automatic tick();
        pix_t exp_p, act_p;
        @(posedge clk);
        #1;
        if (sync_err) err_pulses++;
        if (gen_run) begin
            if (sb_q.size() == 3) begin
                exp_p = sb_q.pop_front();
                if (chk_en) begin
                    act_p = {rx_x, rx_y, rx_de, frame_start};
                    check("align", act_p, exp_p);
                end
            end
            if (tx_h == HT - 1) begin
                tx_h = 0;
                tx_v = (tx_v == VT - 1) ? 0 : tx_v + 1;
            end else begin
                tx_h++;
            end
            drive_pins();
            push_cur();
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic to_frame_start();
        int b;
        b = 0;
        while (!(tx_h == 0 && tx_v == 0) && b <= FRAME) begin
            tick();
            b++;
        end
    endtask

    task automatic wait_lock(input int budget, output int cyc);
        cyc = 0;
        while (!locked && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic acquire_check(input string tag);
        int c;
        err_pulses = 0;
        wait_lock(4 * FRAME, c);
        check_range({tag, "_lock_time"}, c, 2 * FRAME, 3 * FRAME + HT + 8);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_err_pulses"}, err_pulses, 0);
    endtask

    initial begin
        int c;
        vecs[0] = '{"clean",     0,  0, 0,  0, 0, 1, 0,         0};
        vecs[1] = '{"hs_early", -1,  0, 0,  0, 1, 0, FRAME,     2 * FRAME};
        vecs[2] = '{"hs_late",   1,  0, 0,  0, 1, 0, FRAME,     2 * FRAME};
        vecs[3] = '{"hs_short",  0, -1, 0,  0, 1, 0, FRAME,     2 * FRAME};
        vecs[4] = '{"hs_long",   0,  1, 0,  0, 1, 0, FRAME,     2 * FRAME};
        vecs[5] = '{"hs_skip",   0,  0, 1,  0, 0, 1, 0,         0};
        vecs[6] = '{"vs_early",  0,  0, 0, -1, 1, 0, 2 * FRAME, 3 * FRAME};
        vecs[7] = '{"vs_late",   0,  0, 0,  1, 1, 0, 2 * FRAME, 3 * FRAME};

        drive_pins();
        run(5);
        check("reset_outputs", {rx_x, rx_y, rx_de, frame_start, locked, sync_err, err_count}, 0);

        sb_q.delete();
        reset_n = 1'b1;
        gen_run = 1'b1;
        push_cur();
        acquire_check("init");

        to_frame_start();
        chk_en = 1'b1;
        run(FRAME);
        chk_en = 1'b0;

        foreach (vecs[i]) begin
            if (!locked) begin
                wait_lock(4 * FRAME, c);
                check({vecs[i].name, "_prelock"}, locked, 1);
            end
            to_frame_start();
            err_pulses = 0;
            f_sa = vecs[i].sa;
            f_ea = vecs[i].ea;
            f_skip = vecs[i].skip;
            f_vsa = vecs[i].vsa;
            fault_line = 3;
            chk_en = vecs[i].exp_locked && (vecs[i].exp_errs == 0);
            run(FRAME);
            fault_line = -1;
            f_sa = 0; f_ea = 0; f_skip = 0; f_vsa = 0;
            run(8);
            chk_en = 1'b0;
            exp_err = (exp_err + vecs[i].exp_errs > 255) ? 255 : exp_err + vecs[i].exp_errs;
            check({vecs[i].name, "_pulses"}, err_pulses, vecs[i].exp_errs);
            check({vecs[i].name, "_count"}, err_count, exp_err);
            check({vecs[i].name, "_locked"}, locked, vecs[i].exp_locked);
            if (!vecs[i].exp_locked) begin
                wait_lock(4 * FRAME, c);
                check_range({vecs[i].name, "_relock"}, c, vecs[i].relock_lo, vecs[i].relock_hi);
            end
        end

        to_frame_start();
        err_pulses = 0;
        vs_en = 1'b0;
        chk_en = 1'b1;
        run(3 * FRAME);
        check("novs_locked", locked, 1);
        vs_en = 1'b1;
        run(FRAME);
        chk_en = 1'b0;
        check("novs_pulses", err_pulses, 0);
        check("novs_relocked", locked, 1);

        to_frame_start();
        err_pulses = 0;
        all_lines_fault = 1'b1;
        f_ea = -1;
        run(100 * HT);
        check("sat_100", err_count, (exp_err + 100 > 255) ? 255 : exp_err + 100);
        run(200 * HT);
        all_lines_fault = 1'b0;
        f_ea = 0;
        run(8);
        check("sat_count", err_count, 255);
        check("sat_pulses", err_pulses, 300);

        wait_lock(4 * FRAME, c);
        check("pre_reset_locked", locked, 1);
        c = 0;
        while (!(tx_v == 5 && tx_h == 8) && c <= FRAME) begin
            tick();
            c++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {rx_x, rx_y, rx_de, frame_start, locked, sync_err, err_count}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        acquire_check("mid_reset");
        to_frame_start();
        chk_en = 1'b1;
        run(FRAME);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
